ha_token_buf: RTL and testbench

HA_TOKEN_BUF -- requirements
Module: ha_token_buf

---
 rtl/ha_pkg.sv | 16 +
 rtl/ha_token_ram.sv | 24 ++
 rtl/ha_token_buf.sv | 111 +++++++++++
 tb/tb_ha_token_buf.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ha_pkg.sv
// Shared constants and sizing helpers for the ha_* token-buffer blocks.
package ha_pkg;

  localparam int HA_BW_DEFAULT    = 32;
  localparam int HA_DEPTH_DEFAULT = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int HA_CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int ha_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ha_token_ram.sv
// Token storage: DEPTH x W, one synchronous write port, one asynchronous read port.
module ha_token_ram #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // No reset: stale contents are never visible because occupancy gates the output.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ha_token_buf.sv
// Valid/ready token FIFO between input and output wrappers, one-cycle latency.
// Optional stall statistics counter enabled by defining HA_TOKEN_BUF_STATS_EN.
module ha_token_buf
  import ha_pkg::*;
#(
  parameter int DataIn_1_BW  = HA_BW_DEFAULT,
  parameter int DataOut_1_BW = HA_BW_DEFAULT,
  parameter int DEPTH        = HA_DEPTH_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DataIn_1_BW-1:0]      DataIn_1,
  input  logic                        DataIn_1_valid,
  output logic                        DataIn_1_ready,
  output logic [DataOut_1_BW-1:0]     DataOut_1,
  output logic                        DataOut_1_valid,
  input  logic                        DataOut_1_ready,
  output logic [HA_CNT_W(DEPTH)-1:0]  count
`ifdef HA_TOKEN_BUF_STATS_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  // Handshake: a token moves on a clock edge where valid && ready are both high.
  // ready depends only on registered state, never on the downstream ready input.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = HA_CNT_W(DEPTH);
  localparam int XW = ha_max(DataIn_1_BW, DataOut_1_BW);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   rst_done_q, rst_done_d;
  logic                   push, pop;
  logic [DataIn_1_BW-1:0] ram_rdata;
  logic [XW-1:0]          rd_ext;

  // rst_done_q keeps ready low until the first edge after reset release.
  assign DataIn_1_ready  = rst_done_q && (count_q != FULL_CNT);
  assign DataOut_1_valid = (count_q != '0);
  assign push            = DataIn_1_valid && DataIn_1_ready;
  assign pop             = DataOut_1_valid && DataOut_1_ready;
  assign count           = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rst_done_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rst_done_q <= rst_done_d;
    end
  end

  ha_token_ram #(
    .DEPTH (DEPTH),
    .W     (DataIn_1_BW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (DataIn_1),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // Widen to the larger width first so narrowing truncates and widening zero-extends.
  always_comb begin
    rd_ext    = XW'(ram_rdata);
    DataOut_1 = DataOut_1_valid ? rd_ext[DataOut_1_BW-1:0] : '0;
  end

`ifdef HA_TOKEN_BUF_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst_done_q && DataIn_1_valid && !DataIn_1_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ha_token_buf.sv
// Self-checking bench for ha_token_buf: reference occupancy model plus expected-token queue.
module tb_ha_token_buf;

  localparam int DEPTH = 4;
  localparam int BW    = 32;

  logic          clk;
  logic          rst;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    count;
`ifdef HA_TOKEN_BUF_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  int            n_checks;
  int            n_pass;
  int            m_cnt;
  logic          m_rdy_en;
  logic [BW-1:0] exp_q[$];

  ha_token_buf #(
    .DataIn_1_BW  (BW),
    .DataOut_1_BW (BW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .DataIn_1        (in_data),
    .DataIn_1_valid  (in_valid),
    .DataIn_1_ready  (in_ready),
    .DataOut_1       (out_data),
    .DataOut_1_valid (out_valid),
    .DataOut_1_ready (out_ready),
    .count           (count)
`ifdef HA_TOKEN_BUF_STATS_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout checks_so_far=%0d", n_checks);
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    logic [31:0] exp_data;
    exp_data = (m_cnt != 0) ? exp_q[0] : 32'd0;
    check("ready", 32'(in_ready), 32'(m_rdy_en && (m_cnt != DEPTH)));
    check("valid", 32'(out_valid), 32'(m_cnt != 0));
    check("count", 32'(count), 32'(m_cnt));
    check("data", out_data, exp_data);
  endtask

  // One clock cycle: drive on negedge, check, then update the model at posedge.
  task automatic cycle(input logic v, input logic [BW-1:0] d, input logic r);
    logic push, pop;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    check_outputs();
    push = v && m_rdy_en && (m_cnt != DEPTH);
    pop  = r && (m_cnt != 0);
    @(posedge clk);
    if (pop)  void'(exp_q.pop_front());
    if (push) exp_q.push_back(d);
    m_cnt    = m_cnt + int'(push) - int'(pop);
    m_rdy_en = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'b1);
  endtask

  task automatic apply_reset_now();
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    m_cnt    = 0;
    m_rdy_en = 1'b0;
    #1;
    check_outputs();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_pre_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    m_rdy_en = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst       = 1'b0;
    m_cnt     = 0;
    m_rdy_en  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    apply_reset_now();
    release_reset();

    // single token
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    cycle(1'b0, '0, 1'b0);
    drain();

    // fill, fifth token held, then full + pop in the same cycle
    for (int i = 1; i <= 4; i++) cycle(1'b1, BW'(i), 1'b0);
    cycle(1'b1, 32'd5, 1'b0);
    cycle(1'b1, 32'd5, 1'b1);
    cycle(1'b1, 32'd5, 1'b1);
    drain();

    // streaming with pointer wrap
    for (int i = 0; i < 20; i++) cycle(1'b1, BW'(i), 1'b1);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'(($urandom_range(0, 3) != 0)), BW'($urandom), 1'(($urandom_range(0, 2) != 0)));
    drain();

    // reset mid-operation with three tokens stored
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'hA000_0000 + BW'(i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    #3;
    apply_reset_now();
    release_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h0000_0BB0, 1'b0);
    cycle(1'b0, '0, 1'b1);
    drain();

`ifdef HA_TOKEN_BUF_STATS_EN
    @(negedge clk);
    apply_reset_now();
    release_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, BW'(i), 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'hFF, 1'b0);
    @(negedge clk);
    check("stall_cnt_7", stall_cnt, 32'd7);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    cycle(1'b1, 32'hFF, 1'b0);
    cycle(1'b1, 32'hFF, 1'b0);
    @(negedge clk);
    check("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
    in_valid = 1'b0;
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
